vend_arbiter: RTL and testbench



---
 rtl/vend_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_vend_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_arbiter.sv
// vend_arbiter: shares one vending core between two customer panels (A, B).
// Loads core prices after reset, then runs round-robin sessions with per-product stock tracking.
module vend_arbiter #(
  parameter logic [7:0]         PRICE0     = 8'd10,
  parameter logic [7:0]         PRICE1     = 8'd15,
  parameter logic [7:0]         PRICE2     = 8'd20,
  parameter int unsigned        STOCK_W    = 4,
  parameter logic [STOCK_W-1:0] STOCK_INIT = 4'd3,
  parameter logic [7:0]         TIMEOUT    = 8'd50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_a,
  input  logic               req_b,
  input  logic [7:0]         mi_a,
  input  logic [7:0]         mi_b,
  input  logic [1:0]         sel_a,
  input  logic [1:0]         sel_b,
  input  logic               re_a,
  input  logic               re_b,
  input  logic               restock,
  input  logic [1:0]         restock_id,
  input  logic [STOCK_W-1:0] restock_qty,
  output logic [7:0]         core_di,
  output logic [7:0]         core_mi,
  output logic [1:0]         core_sel,
  output logic               core_re,
  input  logic [7:0]         core_mo,
  input  logic [1:0]         core_po,
  output logic               gnt_a,
  output logic               gnt_b,
  output logic               out_valid,
  output logic               out_owner,
  output logic [7:0]         mo,
  output logic [1:0]         po,
  output logic               sel_reject,
  output logic [2:0]         sold_out,
  output logic               cfg_done
);

  typedef enum logic [2:0] {
    StCfg,
    StIdle,
    StSession,
    StWaitResp,
    StRelease
  } state_e;

  localparam logic [STOCK_W:0] StockMax = {1'b0, {STOCK_W{1'b1}}};
  localparam logic [STOCK_W:0] StockOne = {{STOCK_W{1'b0}}, 1'b1};

  state_e     state_q, state_d;
  logic [1:0] cfg_cnt_q, cfg_cnt_d;
  logic       cfg_done_q, cfg_done_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic       refund_q, refund_d;
  logic       out_valid_q, out_valid_d;
  logic       out_owner_q, out_owner_d;
  logic [7:0] mo_q, mo_d;
  logic [1:0] po_q, po_d;

  logic [7:0] own_mi;
  logic [1:0] own_sel;
  logic       own_re;
  logic       win_b;

  assign own_mi  = owner_q ? mi_b  : mi_a;
  assign own_sel = owner_q ? sel_b : sel_a;
  assign own_re  = owner_q ? re_b  : re_a;
  // On a tie the panel that did not own the core last wins.
  assign win_b   = (req_a && req_b) ? ~last_owner_q : req_b;

  always_comb begin
    state_d      = state_q;
    cfg_cnt_d    = cfg_cnt_q;
    cfg_done_d   = cfg_done_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_a_d      = gnt_a_q;
    gnt_b_d      = gnt_b_q;
    idle_cnt_d   = idle_cnt_q;
    refund_d     = refund_q;
    out_valid_d  = 1'b0;
    out_owner_d  = out_owner_q;
    mo_d         = mo_q;
    po_d         = po_q;
    core_di      = 8'd0;
    core_mi      = 8'd0;
    core_sel     = 2'd0;
    core_re      = 1'b0;
    sel_reject   = 1'b0;

    unique case (state_q)
      StCfg: begin
        unique case (cfg_cnt_q)
          2'd0:    core_di = PRICE0;
          2'd1:    core_di = PRICE1;
          2'd2:    core_di = PRICE2;
          default: core_di = 8'd0;
        endcase
        if (cfg_cnt_q == 2'd2) begin
          cfg_cnt_d  = 2'd0;
          cfg_done_d = 1'b1;
          state_d    = StIdle;
        end else begin
          cfg_cnt_d = cfg_cnt_q + 2'd1;
        end
      end

      StIdle: begin
        idle_cnt_d = 8'd0;
        if (req_a || req_b) begin
          owner_d  = win_b;
          gnt_a_d  = ~win_b;
          gnt_b_d  = win_b;
          refund_d = 1'b0;
          state_d  = StSession;
        end
      end

      StSession: begin
        core_mi = own_mi;
        if (idle_cnt_q == TIMEOUT) begin
          core_re    = 1'b1;
          refund_d   = 1'b1;
          idle_cnt_d = 8'd0;
          state_d    = StWaitResp;
        end else if (own_re) begin
          core_re    = 1'b1;
          refund_d   = 1'b1;
          idle_cnt_d = 8'd0;
          state_d    = StWaitResp;
        end else if (own_sel != 2'd0) begin
          idle_cnt_d = 8'd0;
          // Sold-out picks never reach the core; money still does.
          if (sold_out[own_sel - 2'd1]) begin
            sel_reject = 1'b1;
          end else begin
            core_sel = own_sel;
            refund_d = 1'b0;
            state_d  = StWaitResp;
          end
        end else if (own_mi != 8'd0) begin
          idle_cnt_d = 8'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end

      StWaitResp: begin
        out_valid_d = 1'b1;
        out_owner_d = owner_q;
        mo_d        = core_mo;
        po_d        = core_po;
        if ((core_po != 2'd0) || refund_q) begin
          gnt_a_d = 1'b0;
          gnt_b_d = 1'b0;
          state_d = StRelease;
        end else begin
          // Not enough money: the core keeps the balance and the session goes on.
          state_d = StSession;
        end
      end

      StRelease: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end

      default: state_d = StCfg;
    endcase

    if (rst) begin
      core_di = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StCfg;
      cfg_cnt_q    <= 2'd0;
      cfg_done_q   <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      idle_cnt_q   <= 8'd0;
      refund_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_owner_q  <= 1'b0;
      mo_q         <= 8'd0;
      po_q         <= 2'd0;
    end else begin
      state_q      <= state_d;
      cfg_cnt_q    <= cfg_cnt_d;
      cfg_done_q   <= cfg_done_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_a_q      <= gnt_a_d;
      gnt_b_q      <= gnt_b_d;
      idle_cnt_q   <= idle_cnt_d;
      refund_q     <= refund_d;
      out_valid_q  <= out_valid_d;
      out_owner_q  <= out_owner_d;
      mo_q         <= mo_d;
      po_q         <= po_d;
    end
  end

  // Per-product stock: restock and sale may hit the same counter in one cycle.
  for (genvar i = 0; i < 3; i++) begin : g_stock
    logic               add_hit;
    logic               dec_hit;
    logic [STOCK_W:0]   sum;
    logic [STOCK_W-1:0] stock_d;
    logic [STOCK_W-1:0] stock_q;

    assign add_hit = restock && (restock_id == 2'(i + 1));
    assign dec_hit = (state_q == StWaitResp) && (core_po == 2'(i + 1));

    always_comb begin
      sum = {1'b0, stock_q} + (add_hit ? {1'b0, restock_qty} : StockMax & '0);
      if (dec_hit && (sum != '0)) begin
        sum = sum - StockOne;
      end
      stock_d = (sum > StockMax) ? {STOCK_W{1'b1}} : sum[STOCK_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stock_q <= STOCK_INIT;
      end else begin
        stock_q <= stock_d;
      end
    end

    assign sold_out[i] = (stock_q == '0);
  end

  assign gnt_a     = gnt_a_q;
  assign gnt_b     = gnt_b_q;
  assign out_valid = out_valid_q;
  assign out_owner = out_owner_q;
  assign mo        = mo_q;
  assign po        = po_q;
  assign cfg_done  = cfg_done_q;

endmodule

// File: tb/tb_vend_arbiter.sv
// Bench for vend_arbiter: behavioural vending-core stub plus a transaction-level model of
// balances, stock and round-robin ownership; randomized sessions between directed scenarios.
module tb_vend_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a, req_b, re_a, re_b, restock;
  logic [7:0] mi_a, mi_b;
  logic [1:0] sel_a, sel_b, restock_id;
  logic [3:0] restock_qty;
  logic [7:0] core_di, core_mi, core_mo, mo;
  logic [1:0] core_sel, core_po, po;
  logic       core_re, gnt_a, gnt_b, out_valid, out_owner, sel_reject, cfg_done;
  logic [2:0] sold_out;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state
  int mstock [3];
  int mbal;
  bit mlast;
  bit cur_owner;

  // Vending core stub state
  int         core_bal = 0;
  int         ccfg = 0;
  logic [7:0] cprice [3];

  vend_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .mi_a(mi_a), .mi_b(mi_b),
    .sel_a(sel_a), .sel_b(sel_b), .re_a(re_a), .re_b(re_b),
    .restock(restock), .restock_id(restock_id), .restock_qty(restock_qty),
    .core_di(core_di), .core_mi(core_mi), .core_sel(core_sel), .core_re(core_re),
    .core_mo(core_mo), .core_po(core_po),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .out_valid(out_valid), .out_owner(out_owner),
    .mo(mo), .po(po), .sel_reject(sel_reject), .sold_out(sold_out), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  // Core: takes 3 prices after reset, answers one cycle after sel/re.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_bal <= 0;
      ccfg     <= 0;
      core_mo  <= 8'd0;
      core_po  <= 2'd0;
    end else begin
      if (ccfg < 3) begin
        cprice[ccfg] <= core_di;
        ccfg         <= ccfg + 1;
      end
      core_mo <= 8'd0;
      core_po <= 2'd0;
      if (core_re) begin
        core_mo  <= 8'(core_bal + int'(core_mi));
        core_bal <= 0;
      end else if (core_sel != 2'd0) begin
        if (core_bal + int'(core_mi) >= int'(cprice[int'(core_sel) - 1])) begin
          core_mo  <= 8'(core_bal + int'(core_mi) - int'(cprice[int'(core_sel) - 1]));
          core_po  <= core_sel;
          core_bal <= 0;
        end else begin
          core_bal <= core_bal + int'(core_mi);
        end
      end else begin
        core_bal <= core_bal + int'(core_mi);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int price(input int k);
    case (k)
      1:       return 10;
      2:       return 15;
      default: return 20;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 15) ? 15 : v);
  endfunction

  function automatic logic [2:0] msold();
    return {mstock[2] == 0, mstock[1] == 0, mstock[0] == 0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Owner inputs idle; non-owner panel gets random noise that must never reach the core.
  task automatic clear_in();
    req_a = 0; req_b = 0; mi_a = 0; mi_b = 0; sel_a = 0; sel_b = 0; re_a = 0; re_b = 0;
    restock = 0; restock_id = 0; restock_qty = 0;
    if (cur_owner) begin
      mi_a = 8'($urandom_range(0, 30)); sel_a = 2'($urandom_range(0, 3));
      re_a = 1'($urandom_range(0, 1));
    end else begin
      mi_b = 8'($urandom_range(0, 30)); sel_b = 2'($urandom_range(0, 3));
      re_b = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic cfg_seq(input bit do_rs);
    @(negedge clk); rst = 1'b0; clear_in(); req_a = 1; req_b = 1;
    if (do_rs) begin
      restock = 1; restock_id = 2'd2; restock_qty = 4'd4;
      mstock[1] = sat(mstock[1] + 4);
    end
    #1; check("cfg_di0", core_di, 10); check("cfg_done_early", cfg_done, 0);
    @(negedge clk); clear_in(); req_a = 1; req_b = 1; #1; check("cfg_di1", core_di, 15);
    @(negedge clk); clear_in(); req_a = 1; req_b = 1; #1; check("cfg_di2", core_di, 20);
    @(negedge clk); clear_in(); #1;
    check("cfg_done", cfg_done, 1); check("cfg_di_off", core_di, 0);
    check("cfg_no_gnt", {gnt_a, gnt_b}, 0);
  endtask

  task automatic request(input bit a, input bit b);
    bit exp_b;
    bit found;
    exp_b = (a && b) ? ~mlast : b;
    found = 0;
    @(negedge clk); clear_in(); req_a = a; req_b = b;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) found = 1;
    end
    check("grant_seen", found, 1);
    check("grant", {gnt_a, gnt_b}, exp_b ? 2'b01 : 2'b10);
    cur_owner = exp_b;
    mbal = 0;
    clear_in();
  endtask

  task automatic coin(input int amt);
    @(negedge clk); clear_in();
    if (cur_owner) mi_b = 8'(amt); else mi_a = 8'(amt);
    #1;
    check("core_mi", core_mi, amt);
    check("core_sel_quiet", core_sel, 0);
    check("core_re_quiet", core_re, 0);
    mbal += amt;
  endtask

  task automatic wait_result(input int emo, input int epo, input bit rel,
                             input int rid, input int rqty);
    bit found;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk); clear_in();
      if (i == 0 && rid != 0) begin
        restock = 1; restock_id = 2'(rid); restock_qty = 4'(rqty);
      end
      #1;
      if (out_valid === 1'b1) found = 1;
    end
    check("out_valid", found, 1);
    check("mo", mo, emo);
    check("po", po, epo);
    check("out_owner", out_owner, cur_owner);
    if (rel) begin
      check("gnt_released", {gnt_a, gnt_b}, 0);
      mlast = cur_owner;
    end else begin
      check("gnt_held", {gnt_a, gnt_b}, cur_owner ? 2'b01 : 2'b10);
    end
    @(negedge clk); clear_in(); #1;
    check("out_valid_pulse", out_valid, 0);
    check("sold_out", sold_out, msold());
  endtask

  task automatic do_select(input int s, input int rid, input int rqty, output bit rel);
    bit vend;
    int emo;
    @(negedge clk); clear_in();
    if (cur_owner) sel_b = 2'(s); else sel_a = 2'(s);
    #1;
    rel = 0;
    if (mstock[s-1] == 0) begin
      check("sel_reject", sel_reject, 1);
      check("core_sel_blocked", core_sel, 0);
    end else begin
      check("sel_reject_n", sel_reject, 0);
      check("core_sel", core_sel, s);
      vend = (mbal >= price(s));
      emo  = vend ? mbal - price(s) : 0;
      if (vend) mbal = 0;
      for (int j = 0; j < 3; j++) begin
        mstock[j] = sat(mstock[j] + ((rid == j + 1) ? rqty : 0) - ((vend && s == j + 1) ? 1 : 0));
      end
      rel = vend;
      wait_result(emo, vend ? s : 0, vend, rid, rqty);
    end
  endtask

  task automatic do_refund(input bit also_sel);
    int emo;
    @(negedge clk); clear_in();
    if (cur_owner) begin
      re_b = 1; if (also_sel) sel_b = 2'($urandom_range(1, 3));
    end else begin
      re_a = 1; if (also_sel) sel_a = 2'($urandom_range(1, 3));
    end
    #1;
    check("core_re", core_re, 1);
    check("core_sel_on_refund", core_sel, 0);
    emo = mbal; mbal = 0;
    wait_result(emo, 0, 1, 0, 0);
  endtask

  task automatic do_restock(input int id, input int qty);
    @(negedge clk); clear_in();
    restock = 1; restock_id = 2'(id); restock_qty = 4'(qty);
    if (id != 0) mstock[id-1] = sat(mstock[id-1] + qty);
    @(negedge clk); clear_in(); #1;
    check("sold_out_restock", sold_out, msold());
  endtask

  task automatic idle_quiet(input int n);
    bit early;
    early = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clear_in(); #1;
      if (core_re) early = 1;
    end
    check("no_early_refund", early, 0);
  endtask

  task automatic expect_timeout();
    int emo;
    idle_quiet(50);
    @(negedge clk); clear_in(); #1;
    check("timeout_re", core_re, 1);
    emo = mbal; mbal = 0;
    wait_result(emo, 0, 1, 0, 0);
  endtask

  initial begin
    bit rel;
    int r;
    for (int j = 0; j < 3; j++) mstock[j] = 3;
    mlast = 1; cur_owner = 0; mbal = 0;
    clear_in();

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_gnt", {gnt_a, gnt_b}, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mo_po", {mo, po, out_owner}, 0);
    check("rst_sold_out", sold_out, 0);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_core_out", {core_di, core_mi, core_sel, core_re, sel_reject}, 0);
    cfg_seq(0);

    // A buys product 2 with 20
    request(1, 0);
    coin(10); coin(10);
    do_select(2, 0, 0, rel);

    // Tie goes to B after A, then back to A
    request(1, 1); do_refund(0);
    request(1, 1); do_refund(1);

    // Insufficient money keeps the session; topping up completes the sale
    request(0, 1);
    coin(5); do_select(3, 0, 0, rel);
    coin(15); do_select(3, 0, 0, rel);

    // Randomized sessions
    for (int it = 0; it < 25; it++) begin
      r = $urandom_range(1, 3);
      request(r[0], r[1]);
      for (int k = $urandom_range(0, 3); k > 0; k--) coin($urandom_range(1, 12));
      if ($urandom_range(0, 3) == 0) begin
        do_refund(1'($urandom_range(0, 1)));
      end else begin
        do_select($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 15), rel);
        if (!rel) do_refund(0);
      end
      if ($urandom_range(0, 2) == 0) do_restock($urandom_range(0, 3), $urandom_range(1, 6));
    end

    // Drain product 1, then a blocked pick and a restock
    for (int it = 0; it < 20 && mstock[0] > 0; it++) begin
      request(1, 0); coin(10); do_select(1, 0, 0, rel);
    end
    check("sold_out0_set", sold_out[0], 1);
    request(0, 1);
    coin(5);
    @(negedge clk); clear_in(); sel_b = 2'd1; mi_b = 8'd4; cur_owner = 1; #1;
    check("reject_pulse", sel_reject, 1);
    check("reject_core_sel", core_sel, 0);
    check("reject_core_mi", core_mi, 4);
    mbal += 4;
    do_refund(0);
    do_restock(1, 2);
    check("sold_out0_clear", sold_out[0], 0);

    // Idle timeout, then timeout restarted by activity
    request(1, 0); coin(7); expect_timeout();
    request(0, 1); coin(7); idle_quiet(40); coin(3); expect_timeout();

    // Reset in mid-session drops everything
    request(1, 0); coin(9);
    @(negedge clk); clear_in(); #2 rst = 1'b1; #1;
    check("mid_rst_gnt", {gnt_a, gnt_b}, 0);
    check("mid_rst_cfg_done", cfg_done, 0);
    check("mid_rst_core", {core_di, core_mi, core_re}, 0);
    for (int j = 0; j < 3; j++) mstock[j] = 3;
    mlast = 1; mbal = 0;
    check("mid_rst_sold_out", sold_out, msold());
    @(negedge clk);
    cfg_seq(1);
    request(1, 1);
    coin(10); do_select(1, 0, 0, rel);
    coin(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
